potential_accumulator_array: RTL and testbench



---
 rtl/potential_accumulator_array.sv | 137 +++++++++++++
 tb/tb_potential_accumulator_array.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/potential_accumulator_array.sv
// rtl/potential_accumulator_array.sv - time-multiplexed LIF membrane-potential accumulate/scan engine
// Optional macro POTENTIAL_SAT_EN: saturating accumulate instead of modulo wrap.
module potential_accumulator_array #(
  parameter int NUM_NEURONS = 10,
  parameter int DATA_W      = 16,
  parameter int DECAY_SHIFT = 1,
  localparam int ID_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                     CLK,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ID_W-1:0]          in_id,
  input  logic signed [DATA_W-1:0] in_weight,
  input  logic                     timestep_end,
  input  logic signed [DATA_W-1:0] v_threshold,
  input  logic signed [DATA_W-1:0] v_reset,
  output logic                     spike_valid,
  output logic [ID_W-1:0]          spike_id,
  output logic                     done,
  output logic                     busy,
  output logic                     overrun,
  output logic                     bad_id,
  input  logic [ID_W-1:0]          rd_id,
  output logic signed [DATA_W-1:0] rd_potential
);

  localparam logic [1:0] S_ACCUM = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]               r_state;
  logic [ID_W-1:0]          r_idx;
  logic signed [DATA_W-1:0] r_pot [NUM_NEURONS];
  logic                     r_spike_valid;
  logic [ID_W-1:0]          r_spike_id;
  logic                     r_overrun;
  logic                     r_bad_id;

  logic                     w_in_range;
  logic                     w_rd_range;
  logic [ID_W-1:0]          w_wr_id;
  logic [ID_W-1:0]          w_rd_id;
  logic signed [DATA_W-1:0] w_cur;
  logic signed [DATA_W-1:0] w_acc;
  logic signed [DATA_W-1:0] w_scan_pot;
  logic signed [DATA_W-1:0] w_decay;
  logic                     w_fire;

  // Out-of-range ids are steered to entry 0 so the array is never indexed past its end.
  assign w_in_range = int'(in_id) < NUM_NEURONS;
  assign w_rd_range = int'(rd_id) < NUM_NEURONS;
  assign w_wr_id    = w_in_range ? in_id : '0;
  assign w_rd_id    = w_rd_range ? rd_id : '0;
  assign w_cur      = r_pot[w_wr_id];

`ifdef POTENTIAL_SAT_EN
  logic signed [DATA_W:0] w_sum;
  assign w_sum = {w_cur[DATA_W-1], w_cur} + {in_weight[DATA_W-1], in_weight};
  always_comb begin
    w_acc = w_sum[DATA_W-1:0];
    if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
      w_acc = w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign w_acc = w_cur + in_weight;
`endif

  assign w_scan_pot = r_pot[r_idx];
  assign w_fire     = w_scan_pot >= v_threshold;

  generate
    if (DECAY_SHIFT == 0) begin : g_no_leak
      assign w_decay = w_scan_pot;
    end else begin : g_leak
      assign w_decay = w_scan_pot - (w_scan_pot >>> DECAY_SHIFT);
    end
  endgenerate

  always_ff @(posedge CLK or posedge clear) begin
    if (clear) begin
      r_state       <= S_ACCUM;
      r_idx         <= '0;
      r_spike_valid <= 1'b0;
      r_spike_id    <= '0;
      r_overrun     <= 1'b0;
      r_bad_id      <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) r_pot[i] <= '0;
    end else begin
      r_spike_valid <= 1'b0;
      case (r_state)
        S_ACCUM: begin
          if (in_valid) begin
            if (w_in_range) r_pot[w_wr_id] <= w_acc;
            else            r_bad_id       <= 1'b1;
          end
          if (timestep_end) begin
            r_state <= S_SCAN;
            r_idx   <= '0;
          end
        end
        S_SCAN: begin
          if (timestep_end) r_overrun <= 1'b1;
          if (w_fire) begin
            r_pot[r_idx]  <= v_reset;
            r_spike_valid <= 1'b1;
          end else begin
            r_pot[r_idx]  <= w_decay;
          end
          r_spike_id <= r_idx;
          if (int'(r_idx) == NUM_NEURONS - 1) begin
            r_state <= S_DONE;
            r_idx   <= '0;
          end else begin
            r_idx   <= r_idx + ID_W'(1);
          end
        end
        S_DONE: begin
          if (timestep_end) r_overrun <= 1'b1;
          r_state <= S_ACCUM;
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

  assign in_ready     = (r_state == S_ACCUM);
  assign busy         = (r_state == S_SCAN);
  assign done         = (r_state == S_DONE);
  assign spike_valid  = r_spike_valid;
  assign spike_id     = r_spike_id;
  assign overrun      = r_overrun;
  assign bad_id       = r_bad_id;
  assign rd_potential = w_rd_range ? r_pot[w_rd_id] : '0;

endmodule

// File: tb/tb_potential_accumulator_array.sv
// tb/tb_potential_accumulator_array.sv - directed table-driven bench for potential_accumulator_array
module tb_potential_accumulator_array;

  logic               CLK = 1'b0;
  logic               clear = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [3:0]         in_id = '0;
  logic signed [15:0] in_weight = '0;
  logic               timestep_end = 1'b0;
  logic signed [15:0] v_threshold = 16'sd150;
  logic signed [15:0] v_reset = 16'sd0;
  logic               spike_valid;
  logic [3:0]         spike_id;
  logic               done;
  logic               busy;
  logic               overrun;
  logic               bad_id;
  logic [3:0]         rd_id = '0;
  logic signed [15:0] rd_potential;

  int checks = 0;
  int errors = 0;

  potential_accumulator_array #(.NUM_NEURONS(10), .DATA_W(16), .DECAY_SHIFT(1)) dut (
    .CLK(CLK), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .in_weight(in_weight), .timestep_end(timestep_end),
    .v_threshold(v_threshold), .v_reset(v_reset), .spike_valid(spike_valid),
    .spike_id(spike_id), .done(done), .busy(busy), .overrun(overrun),
    .bad_id(bad_id), .rd_id(rd_id), .rd_potential(rd_potential)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int id;
    int w;
    int exp_wrap;
    int exp_sat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_pot(input string name, input int id, input int exp);
    rd_id = 4'(id);
    #1;
    chk(name, int'($signed(rd_potential)), exp);
  endtask

  task automatic write_w(input int id, input int w);
    @(negedge CLK);
    in_valid  = 1'b1;
    in_id     = 4'(id);
    in_weight = 16'(w);
    @(negedge CLK);
    in_valid  = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge CLK);
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
  endtask

  // Pulses timestep_end (optionally with a weight), then watches 25 cycles of the scan.
  task automatic do_scan(input bit with_w, input int wid, input int ww, input int overrun_at,
                         output int busy_cnt, output int done_cnt, output int spike_cnt,
                         output int spk_id, output int spk_cyc);
    busy_cnt = 0; done_cnt = 0; spike_cnt = 0; spk_id = -1; spk_cyc = -1;
    @(negedge CLK);
    timestep_end = 1'b1;
    in_valid     = with_w;
    in_id        = 4'(wid);
    in_weight    = 16'(ww);
    @(negedge CLK);
    timestep_end = 1'b0;
    in_valid     = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (spike_valid) begin
        spike_cnt++;
        spk_id  = int'(spike_id);
        spk_cyc = c;
      end
      timestep_end = (c == overrun_at);
      @(negedge CLK);
    end
    timestep_end = 1'b0;
  endtask

  int bc, dc, sc, sid, scyc;
  int spikes_seen;

  initial begin
    vecs[0]  = '{1,      5,      5,      5};
    vecs[1]  = '{1,     -8,     -3,     -3};
    vecs[2]  = '{1,      3,      0,      0};
    vecs[3]  = '{4,   1000,   1000,   1000};
    vecs[4]  = '{4,   1000,   2000,   2000};
    vecs[5]  = '{9,  32767,  32767,  32767};
    vecs[6]  = '{9, -32768,     -1,     -1};
    vecs[7]  = '{8, -32768, -32768, -32768};
    vecs[8]  = '{8,     -1,  32767, -32768};
    vecs[9]  = '{0,  30000,  30000,  30000};
    vecs[10] = '{0,  30000,  -5536,  32767};

    // Reset state
    repeat (2) @(negedge CLK);
    clear = 1'b0;
    for (int i = 0; i < 10; i++) chk_pot($sformatf("reset_pot%0d", i), i, 0);
    chk_pot("rd_out_of_range", 15, 0);
    chk("reset_in_ready", int'(in_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_bad_id", int'(bad_id), 0);
    spikes_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (spike_valid || done) spikes_seen++;
    end
    chk("idle_no_spike", spikes_seen, 0);

    // Back-to-back accumulate table, including wrap/saturate boundaries
    @(negedge CLK);
    for (int i = 0; i < 11; i++) begin
      in_valid  = 1'b1;
      in_id     = 4'(vecs[i].id);
      in_weight = 16'(vecs[i].w);
      rd_id     = 4'(vecs[i].id);
      @(negedge CLK);
`ifdef POTENTIAL_SAT_EN
      chk($sformatf("acc_vec%0d", i), int'($signed(rd_potential)), vecs[i].exp_sat);
`else
      chk($sformatf("acc_vec%0d", i), int'($signed(rd_potential)), vecs[i].exp_wrap);
`endif
    end
    in_valid = 1'b0;

    // Basic timestep: id3 fires, id5 decays
    do_clear();
    write_w(3, 100);
    write_w(3, 100);
    write_w(5, 40);
    do_scan(1'b0, 0, 0, -1, bc, dc, sc, sid, scyc);
    chk("ts1_busy_cycles", bc, 10);
    chk("ts1_done_pulses", dc, 1);
    chk("ts1_spike_count", sc, 1);
    chk("ts1_spike_id", sid, 3);
    chk("ts1_spike_cycle", scyc, 4);
    chk_pot("ts1_pot3", 3, 0);
    chk_pot("ts1_pot5", 5, 20);
    chk("ts1_in_ready", int'(in_ready), 1);

    // Weight on the same cycle as timestep_end is seen by the scan
    do_scan(1'b1, 2, 200, -1, bc, dc, sc, sid, scyc);
    chk("ts2_spike_count", sc, 1);
    chk("ts2_spike_id", sid, 2);
    chk_pot("ts2_pot2", 2, 0);
    chk_pot("ts2_pot5", 5, 10);

    // Threshold equality, negative decay, overrun mid-scan
    write_w(6, 150);
    write_w(7, 149);
    write_w(1, -7);
    do_scan(1'b0, 0, 0, 3, bc, dc, sc, sid, scyc);
    chk("ts3_busy_cycles", bc, 10);
    chk("ts3_done_pulses", dc, 1);
    chk("ts3_spike_count", sc, 1);
    chk("ts3_spike_id", sid, 6);
    chk("ts3_overrun", int'(overrun), 1);
    chk_pot("ts3_pot7", 7, 75);
    chk_pot("ts3_pot1", 1, -3);
    chk_pot("ts3_pot5", 5, 5);

    // Out-of-range id: handshake completes, no write, sticky flag
    write_w(12, 50);
    chk("bad_id_set", int'(bad_id), 1);
    chk_pot("bad_id_pot0", 0, 0);
    chk_pot("bad_id_pot4", 4, 0);
    chk_pot("bad_id_pot7", 7, 75);
    chk("bad_id_in_ready", int'(in_ready), 1);

    // Clear aborts a scan at index 4
    do_clear();
    chk("clear_overrun", int'(overrun), 0);
    chk("clear_bad_id", int'(bad_id), 0);
    write_w(7, 300);
    @(negedge CLK);
    timestep_end = 1'b1;
    @(negedge CLK);
    timestep_end = 1'b0;
    repeat (4) @(negedge CLK);
    chk("abort_busy_before", int'(busy), 1);
    clear = 1'b1;
    #1;
    chk("abort_busy_async", int'(busy), 0);
    chk("abort_in_ready_async", int'(in_ready), 1);
    @(negedge CLK);
    clear = 1'b0;
    spikes_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (spike_valid || done || busy) spikes_seen++;
    end
    chk("abort_no_activity", spikes_seen, 0);
    for (int i = 0; i < 10; i++) chk_pot($sformatf("abort_pot%0d", i), i, 0);
    chk("abort_in_ready", int'(in_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
